// File: rtl/screen_layer_arbiter_if.sv
// Fetch handshake between the layer arbiter and its two pixel sources.
// Latency: none, wires only.
// Backpressure: the arbiter holds a request until the selected source acks or it gives up.
interface screen_layer_arbiter_if;
    // one-hot request, bit N addresses layer N
    logic [1:0]  req_o;
    // window-local coordinates of the requested pixel
    logic [15:0] req_x_o;
    logic [15:0] req_y_o;
    // per-layer data-valid
    logic [1:0]  ack_i;
    // layer pixel data, valid alongside the matching ack bit
    logic [15:0] l0_data_i;
    logic [15:0] l1_data_i;

    // arbiter side
    modport master (
        output req_o,
        output req_x_o,
        output req_y_o,
        input  ack_i,
        input  l0_data_i,
        input  l1_data_i
    );

    // pixel source side
    modport slave (
        input  req_o,
        input  req_x_o,
        input  req_y_o,
        output ack_i,
        output l0_data_i,
        output l1_data_i
    );
endinterface

// File: rtl/screen_layer_arbiter.sv
// Picks the owner of the next screen pixel (layer 0, layer 1 or background) and fetches it.
// Latency: update pulse at T -> request at T+3, data one cycle after ack; background at T+3.
// Backpressure: a source may stall up to TIMEOUT request cycles; updates while busy are queued once.
module screen_layer_arbiter #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter logic [15:0] BG_COLOR      = 16'h0000,
    parameter logic [15:0] ERR_COLOR     = 16'hF800,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    // driver side
    input  logic                           pix_update_i,
    input  logic [15:0]                    pix_x_i,
    input  logic [15:0]                    pix_y_i,
    output logic [15:0]                    pix_data_o,
    // layer window configuration, sampled only at frame start
    input  logic                           win0_en,
    input  logic [15:0]                    win0_x0,
    input  logic [15:0]                    win0_y0,
    input  logic [15:0]                    win0_x1,
    input  logic [15:0]                    win0_y1,
    input  logic                           win1_en,
    input  logic [15:0]                    win1_x0,
    input  logic [15:0]                    win1_y0,
    input  logic [15:0]                    win1_x1,
    input  logic [15:0]                    win1_y1,
    // pixel source fetch handshake
    screen_layer_arbiter_if.master         src,
    // status
    output logic                           busy_o,
    output logic                           overrun_o,
    output logic                           timeout_o
);

    // Screen geometry only documents the coordinate range; coordinates are used as given.
    if (SCREEN_WIDTH == 0 || SCREEN_HEIGHT == 0) begin : g_empty_screen
    end

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_DECIDE,
        S_HIT,
        S_REQ
    } state_t;

    // One rectangular layer window, corners inclusive.
    typedef struct packed {
        logic        en;
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
    } win_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(TIMEOUT);

    state_t        state_q;
    win_t          shd0_q;
    win_t          shd1_q;
    logic          sel_q;
    logic [1:0]    req_q;
    logic [15:0]   req_x_q;
    logic [15:0]   req_y_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   pix_data_q;
    logic          busy_q;
    logic          overrun_q;
    logic          timeout_q;
    logic          pending_q;

    win_t          win0_in;
    win_t          win1_in;
    logic          hit0;
    logic          hit1;
    logic          sel_d;
    logic [15:0]   req_x_d;
    logic [15:0]   req_y_d;
    logic          ack_sel;
    logic [15:0]   data_sel;
    logic          fetch_done;

    assign win0_in = '{en: win0_en, x0: win0_x0, y0: win0_y0, x1: win0_x1, y1: win0_y1};
    assign win1_in = '{en: win1_en, x0: win1_x0, y0: win1_y0, x1: win1_x1, y1: win1_y1};

    // An inverted window (x1 < x0 or y1 < y0) can never satisfy both bounds, so it never hits.
    function automatic logic win_hit(input win_t w, input logic [15:0] x, input logic [15:0] y);
        return w.en && (w.x0 <= x) && (x <= w.x1) && (w.y0 <= y) && (y <= w.y1);
    endfunction

    // Window membership against the shadowed config, layer 0 taking priority.
    always_comb begin
        hit0    = win_hit(shd0_q, pix_x_i, pix_y_i);
        hit1    = win_hit(shd1_q, pix_x_i, pix_y_i);
        sel_d   = !hit0;
        req_x_d = hit0 ? (pix_x_i - shd0_q.x0) : (pix_x_i - shd1_q.x0);
        req_y_d = hit0 ? (pix_y_i - shd0_q.y0) : (pix_y_i - shd1_q.y0);
    end

    // Only the selected layer's ack and data matter; the other ack bit is ignored.
    always_comb begin
        ack_sel    = sel_q ? src.ack_i[1] : src.ack_i[0];
        data_sel   = sel_q ? src.l1_data_i : src.l0_data_i;
        fetch_done = 1'b0;
        if (state_q == S_HIT && !(hit0 || hit1)) begin
            fetch_done = 1'b1;
        end
        if (state_q == S_REQ && (ack_sel || cnt_q == REQ_LAST)) begin
            fetch_done = 1'b1;
        end
    end

    // Scheduler FSM with every output registered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_START;
            shd0_q     <= '0;
            shd1_q     <= '0;
            sel_q      <= 1'b0;
            req_q      <= 2'b00;
            req_x_q    <= 16'h0000;
            req_y_q    <= 16'h0000;
            cnt_q      <= '0;
            pix_data_q <= 16'h0000;
            busy_q     <= 1'b1;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            // An update arriving while a fetch is in flight is remembered once.
            if (pix_update_i && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
                pending_q <= 1'b1;
            end

            case (state_q)
                S_START: begin
                    // Prefetch the first pixel before the driver samples it.
                    state_q <= S_DECIDE;
                    busy_q  <= 1'b1;
                end

                S_IDLE: begin
                    if (pix_update_i) begin
                        state_q <= S_DECIDE;
                        busy_q  <= 1'b1;
                    end
                end

                S_DECIDE: begin
                    // Frame start: latch the window config so it cannot change mid-frame.
                    if (pix_x_i == 16'h0000 && pix_y_i == 16'h0000) begin
                        shd0_q <= win0_in;
                        shd1_q <= win1_in;
                    end
                    state_q <= S_HIT;
                end

                S_HIT: begin
                    if (hit0 || hit1) begin
                        sel_q   <= sel_d;
                        req_q   <= sel_d ? 2'b10 : 2'b01;
                        req_x_q <= req_x_d;
                        req_y_q <= req_y_d;
                        cnt_q   <= CW'(1);
                        state_q <= S_REQ;
                    end else begin
                        pix_data_q <= BG_COLOR;
                    end
                end

                S_REQ: begin
                    // Ack is checked first so an ack in the last allowed cycle still wins.
                    if (ack_sel) begin
                        pix_data_q <= data_sel;
                        req_q      <= 2'b00;
                    end else if (cnt_q == REQ_LAST) begin
                        pix_data_q <= ERR_COLOR;
                        timeout_q  <= 1'b1;
                        req_q      <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_START;
                    req_q   <= 2'b00;
                    busy_q  <= 1'b1;
                end
            endcase

            // Completion: serve a queued update straight away, else go idle.
            if (fetch_done) begin
                if (pending_q || pix_update_i) begin
                    state_q   <= S_DECIDE;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b1;
                end else begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign pix_data_o  = pix_data_q;
    assign src.req_o   = req_q;
    assign src.req_x_o = req_x_q;
    assign src.req_y_o = req_y_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_screen_layer_arbiter.sv
// Directed bench for screen_layer_arbiter: background, hits, priority, shadowing, timeout, overrun, reset.
// Latency: checks are taken 1 ns after the rising edge.
// Backpressure: the bench plays both pixel sources and acks at chosen cycles.
module tb_screen_layer_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pix_update_i;
    logic [15:0] pix_x_i;
    logic [15:0] pix_y_i;
    logic [15:0] pix_data_o;
    logic        win0_en, win1_en;
    logic [15:0] win0_x0, win0_y0, win0_x1, win0_y1;
    logic [15:0] win1_x0, win1_y0, win1_x1, win1_y1;
    logic        busy_o, overrun_o, timeout_o;

    int checks = 0;
    int errors = 0;

    screen_layer_arbiter_if src_if ();

    screen_layer_arbiter #(
        .SCREEN_WIDTH (320),
        .SCREEN_HEIGHT(240),
        .BG_COLOR     (16'h0000),
        .ERR_COLOR    (16'hF800),
        .TIMEOUT      (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .pix_update_i(pix_update_i),
        .pix_x_i     (pix_x_i),
        .pix_y_i     (pix_y_i),
        .pix_data_o  (pix_data_o),
        .win0_en     (win0_en),
        .win0_x0     (win0_x0),
        .win0_y0     (win0_y0),
        .win0_x1     (win0_x1),
        .win0_y1     (win0_y1),
        .win1_en     (win1_en),
        .win1_x0     (win1_x0),
        .win1_y0     (win1_y0),
        .win1_x1     (win1_x1),
        .win1_y1     (win1_y1),
        .src         (src_if),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Update pulse during cycle T; coordinates move at its end. Returns in cycle T+1.
    task automatic update_to(input logic [15:0] x, input logic [15:0] y);
        pix_update_i = 1'b1;
        tick(1);
        pix_update_i = 1'b0;
        pix_x_i      = x;
        pix_y_i      = y;
    endtask

    initial begin
        sys_rst      = 1'b1;
        pix_update_i = 1'b0;
        pix_x_i      = 16'd0;
        pix_y_i      = 16'd0;
        win0_en = 1'b0; win0_x0 = 16'd10; win0_y0 = 16'd10; win0_x1 = 16'd19; win0_y1 = 16'd19;
        win1_en = 1'b0; win1_x0 = 16'd15; win1_y0 = 16'd15; win1_x1 = 16'd30; win1_y1 = 16'd30;
        src_if.ack_i     = 2'b00;
        src_if.l0_data_i = 16'h0000;
        src_if.l1_data_i = 16'h0000;

        // ---- reset state
        tick(3);
        check("rst_pix", 32'(pix_data_o), 32'h0000);
        check("rst_req", 32'(src_if.req_o), 32'h0);
        check("rst_reqx", 32'(src_if.req_x_o), 32'h0);
        check("rst_reqy", 32'(src_if.req_y_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h1);
        check("rst_ovr", 32'(overrun_o), 32'h0);
        check("rst_to", 32'(timeout_o), 32'h0);
        sys_rst = 1'b0;
        tick(4);
        check("start_idle", 32'(busy_o), 32'h0);
        check("start_pix", 32'(pix_data_o), 32'h0000);

        // ---- five background pixels, windows disabled
        for (int k = 1; k <= 5; k++) begin
            update_to(16'(k), 16'd0);
            tick(1);
            check("bg_busy_t2", 32'(busy_o), 32'h1);
            check("bg_req_t2", 32'(src_if.req_o), 32'h0);
            tick(1);
            check("bg_busy_t3", 32'(busy_o), 32'h0);
            check("bg_req_t3", 32'(src_if.req_o), 32'h0);
            check("bg_pix", 32'(pix_data_o), 32'h0000);
        end

        // ---- single window hit, ack in second request cycle
        win0_en = 1'b1;
        update_to(16'd0, 16'd0);
        tick(2);
        check("f0_bg_busy", 32'(busy_o), 32'h0);
        update_to(16'd12, 16'd15);
        tick(2);
        check("w0_req", 32'(src_if.req_o), 32'h1);
        check("w0_reqx", 32'(src_if.req_x_o), 32'd2);
        check("w0_reqy", 32'(src_if.req_y_o), 32'd5);
        tick(1);
        check("w0_req_hold", 32'(src_if.req_o), 32'h1);
        check("w0_pix_hold", 32'(pix_data_o), 32'h0000);
        src_if.ack_i = 2'b01; src_if.l0_data_i = 16'h07E0;
        tick(1);
        src_if.ack_i = 2'b00;
        check("w0_pix", 32'(pix_data_o), 32'h07E0);
        check("w0_req_drop", 32'(src_if.req_o), 32'h0);
        check("w0_busy", 32'(busy_o), 32'h0);

        // ---- overlap: layer 0 wins
        win1_en = 1'b1;
        update_to(16'd0, 16'd0);
        tick(2);
        update_to(16'd15, 16'd15);
        tick(2);
        check("ovl_req", 32'(src_if.req_o), 32'h1);
        check("ovl_reqx", 32'(src_if.req_x_o), 32'd5);
        src_if.ack_i = 2'b01; src_if.l0_data_i = 16'h1234;
        tick(1);
        src_if.ack_i = 2'b00;
        check("ovl_pix", 32'(pix_data_o), 32'h1234);

        // ---- disable layer 0 mid-frame: shadow keeps it active
        win0_en = 1'b0;
        update_to(16'd16, 16'd16);
        tick(2);
        check("shd_req", 32'(src_if.req_o), 32'h1);
        check("shd_reqx", 32'(src_if.req_x_o), 32'd6);
        src_if.ack_i = 2'b01; src_if.l0_data_i = 16'h2222;
        tick(1);
        src_if.ack_i = 2'b00;
        check("shd_pix", 32'(pix_data_o), 32'h2222);

        // ---- new frame: layer 1 now owns the pixel; wrong-layer ack ignored
        update_to(16'd0, 16'd0);
        tick(2);
        check("f1_bg_pix", 32'(pix_data_o), 32'h0000);
        update_to(16'd16, 16'd16);
        tick(2);
        check("l1_req", 32'(src_if.req_o), 32'h2);
        check("l1_reqx", 32'(src_if.req_x_o), 32'd1);
        check("l1_reqy", 32'(src_if.req_y_o), 32'd1);
        src_if.ack_i = 2'b01; src_if.l0_data_i = 16'hDEAD;
        tick(1);
        check("l1_ign_req", 32'(src_if.req_o), 32'h2);
        check("l1_ign_pix", 32'(pix_data_o), 32'h0000);
        src_if.ack_i = 2'b10; src_if.l1_data_i = 16'hABCD;
        tick(1);
        src_if.ack_i = 2'b00;
        check("l1_pix", 32'(pix_data_o), 32'hABCD);

        // ---- ack in the fourth (last) request cycle wins
        update_to(16'd20, 16'd20);
        tick(2);
        check("late_req_t3", 32'(src_if.req_o), 32'h2);
        tick(3);
        check("late_req_t6", 32'(src_if.req_o), 32'h2);
        check("late_pix_hold", 32'(pix_data_o), 32'hABCD);
        src_if.ack_i = 2'b10; src_if.l1_data_i = 16'h5555;
        tick(1);
        src_if.ack_i = 2'b00;
        check("late_pix", 32'(pix_data_o), 32'h5555);
        check("late_to", 32'(timeout_o), 32'h0);
        check("late_req_drop", 32'(src_if.req_o), 32'h0);

        // ---- no ack: exactly four request cycles then error colour
        update_to(16'd21, 16'd21);
        tick(2);
        check("to_req_t3", 32'(src_if.req_o), 32'h2);
        tick(3);
        check("to_req_t6", 32'(src_if.req_o), 32'h2);
        check("to_flag_t6", 32'(timeout_o), 32'h0);
        tick(1);
        check("to_req_t7", 32'(src_if.req_o), 32'h0);
        check("to_pix", 32'(pix_data_o), 32'hF800);
        check("to_flag", 32'(timeout_o), 32'h1);
        check("to_busy", 32'(busy_o), 32'h0);

        // ---- overrun: second update during REQ is served right after
        update_to(16'd22, 16'd22);
        tick(2);
        check("ovr_req", 32'(src_if.req_o), 32'h2);
        check("ovr_flag0", 32'(overrun_o), 32'h0);
        pix_update_i = 1'b1;
        tick(1);
        pix_update_i = 1'b0;
        pix_x_i = 16'd23; pix_y_i = 16'd23;
        check("ovr_flag1", 32'(overrun_o), 32'h1);
        src_if.ack_i = 2'b10; src_if.l1_data_i = 16'h6666;
        tick(1);
        src_if.ack_i = 2'b00;
        check("ovr_pix1", 32'(pix_data_o), 32'h6666);
        check("ovr_busy", 32'(busy_o), 32'h1);
        check("ovr_req_drop", 32'(src_if.req_o), 32'h0);
        tick(1);
        check("ovr_hit_req", 32'(src_if.req_o), 32'h0);
        tick(1);
        check("ovr_req2", 32'(src_if.req_o), 32'h2);
        check("ovr_reqx2", 32'(src_if.req_x_o), 32'd8);
        src_if.ack_i = 2'b10; src_if.l1_data_i = 16'h7777;
        tick(1);
        src_if.ack_i = 2'b00;
        check("ovr_pix2", 32'(pix_data_o), 32'h7777);
        check("ovr_idle", 32'(busy_o), 32'h0);

        // ---- reset in the middle of a layer-0 fetch
        win0_en = 1'b1; win0_x0 = 16'd0; win0_y0 = 16'd0; win0_x1 = 16'd20; win0_y1 = 16'd20;
        update_to(16'd0, 16'd0);
        tick(2);
        check("mr_req", 32'(src_if.req_o), 32'h1);
        sys_rst = 1'b1;
        #1;
        check("mr_req_async", 32'(src_if.req_o), 32'h0);
        check("mr_pix", 32'(pix_data_o), 32'h0000);
        check("mr_ovr", 32'(overrun_o), 32'h0);
        check("mr_to", 32'(timeout_o), 32'h0);
        check("mr_busy", 32'(busy_o), 32'h1);
        tick(1);
        sys_rst = 1'b0;
        tick(2);
        check("mr_hit_req", 32'(src_if.req_o), 32'h0);
        tick(1);
        check("mr_refetch_req", 32'(src_if.req_o), 32'h1);
        check("mr_refetch_x", 32'(src_if.req_x_o), 32'd0);
        src_if.ack_i = 2'b01; src_if.l0_data_i = 16'h0F0F;
        tick(1);
        src_if.ack_i = 2'b00;
        check("mr_pix2", 32'(pix_data_o), 32'h0F0F);
        check("mr_idle", 32'(busy_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
